spi_dac_mc: RTL



---
 rtl/spi_dac_mc.sv | 139 +++++++++++++
 1 files changed

// File: rtl/spi_dac_mc.sv
// Multi-channel SPI DAC write controller.
// After reset it shifts one setup word, then turns each accepted channel/data
// request into a 32-bit write-and-update frame on a mode-0 SPI bus
// (SCLK idles low, MOSI changes while SCLK is low, DAC samples on the rising edge).
module spi_dac_mc #(
   parameter int          DATA_W    = 12,
   parameter int          NUM_CH    = 4,
   parameter int          CLK_DIV   = 2,
   parameter int          CS_GAP    = 2,
   parameter logic [31:0] INIT_WORD = 32'h08000001,
   parameter logic [3:0]  CMD       = 4'h3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_ch,
   input  logic [DATA_W-1:0] in_data,
   output logic              sclk,
   output logic              cs_n,
   output logic              mosi,
   output logic              busy,
   output logic              init_done,
   output logic              err
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

   typedef enum logic [2:0] {
      ST_RST,
      ST_INIT,
      ST_SHIFT,
      ST_GAP,
      ST_IDLE
   } state_t;

   state_t      state;
   logic [31:0] sr;
   logic [4:0]  bit_cnt;
   logic [15:0] div_cnt;
   logic [15:0] gap_cnt;
   logic [15:0] data16;
   logic [31:0] frame;
   logic        ch_ok;

   // Build the outgoing frame from the request: sample left-justified in 16 bits.
   always_comb begin
      data16 = 16'(in_data) << (16 - DATA_W);
      frame  = {4'h0, CMD, in_ch, data16, 4'h0};
      ch_ok  = ({28'd0, in_ch} < 32'(NUM_CH));
   end

   // Controller FSM: setup word, then request-driven frames, each followed by a CS gap.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_RST;
         cs_n      <= 1'b1;
         sclk      <= 1'b0;
         mosi      <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         init_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            ST_RST: begin
               state <= ST_INIT;
            end
            ST_INIT: begin
               // Setup word goes out exactly like a data frame.
               sr      <= INIT_WORD;
               mosi    <= INIT_WORD[31];
               cs_n    <= 1'b0;
               sclk    <= 1'b0;
               busy    <= 1'b1;
               bit_cnt <= 5'd0;
               div_cnt <= 16'd0;
               state   <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= 16'd0;
                  if (!sclk) begin
                     sclk <= 1'b1;
                  end else begin
                     sclk <= 1'b0;
                     if (bit_cnt == 5'd31) begin
                        cs_n    <= 1'b1;
                        mosi    <= 1'b0;
                        gap_cnt <= 16'd0;
                        state   <= ST_GAP;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                        sr      <= {sr[30:0], 1'b0};
                        mosi    <= sr[30];
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 16'd1;
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  init_done <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end
            ST_IDLE: begin
               if (in_valid) begin
                  if (ch_ok) begin
                     sr       <= frame;
                     mosi     <= frame[31];
                     cs_n     <= 1'b0;
                     sclk     <= 1'b0;
                     busy     <= 1'b1;
                     in_ready <= 1'b0;
                     bit_cnt  <= 5'd0;
                     div_cnt  <= 16'd0;
                     state    <= ST_SHIFT;
                  end else begin
                     // Out-of-range channel: handshake completes, nothing is sent.
                     err <= 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_RST;
            end
         endcase
      end
   end

endmodule
